// File: rtl/cache_line_controller.sv
// cache_line_controller: picks a victim on a miss and issues fill / flush+fill,
// sequences flush_all writeback, and stalls requesters while any line is busy.
module cache_line_controller #(
  parameter int NUMLINES = 4,
  parameter int ADDRBITS = 32,
  parameter int LSBBITS  = 7,
  parameter int TTLBITS  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRBITS-1:0]          dcache_rdaddr,
  input  logic                         dcache_rdreq,
  input  logic [ADDRBITS-1:0]          dcache_wraddr,
  input  logic                         dcache_wrreq,
  input  logic [ADDRBITS-1:0]          icache_rdaddr,
  input  logic                         icache_rdreq,
  input  logic [NUMLINES-1:0]          dcache_line_out_valid_vec,
  input  logic [NUMLINES-1:0]          dcache_line_wrhit_vec,
  input  logic [NUMLINES-1:0]          icache_line_out_valid_vec,
  input  logic [NUMLINES-1:0]          cache_line_ready_vec,
  input  logic [NUMLINES-1:0]          cache_line_dirty_vec,
  input  logic [NUMLINES*TTLBITS-1:0]  cache_line_ttl_vec,
  output logic [NUMLINES-1:0]          cache_line_flush_vec,
  output logic [NUMLINES-1:0]          cache_line_fill_vec,
  output logic [ADDRBITS-1:0]          cache_new_region,
  output logic                         dcache_stall,
  output logic                         icache_stall,
  input  logic                         flush_all_req,
  output logic                         flush_all_done
);
  localparam int IW = NUMLINES > 1 ? $clog2(NUMLINES) : 1;

  typedef enum logic [3:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FA_SCAN, FA_ISSUE, FA_WAIT_BUSY, FA_WAIT_DONE, FA_DONE
  } state_t;

  state_t              r_state, w_next;
  logic [IW-1:0]       r_idx, w_vic;
  logic [TTLBITS-1:0]  w_min;
  logic [ADDRBITS-1:0] r_region, w_addr, w_region;
  logic                r_vdirty, r_stall, r_pend;
  logic                w_dwr, w_drd, w_ird, w_miss, w_fa, w_last, w_step;
  logic [NUMLINES-1:0] w_onehot;

  assign w_dwr    = dcache_wrreq & ~|dcache_line_wrhit_vec;
  assign w_drd    = dcache_rdreq & ~|dcache_line_out_valid_vec;
  assign w_ird    = icache_rdreq & ~|icache_line_out_valid_vec;
  assign w_miss   = &cache_line_ready_vec & (w_dwr | w_drd | w_ird);
  assign w_fa     = flush_all_req | r_pend;
  assign w_addr   = w_dwr ? dcache_wraddr : w_drd ? dcache_rdaddr : icache_rdaddr;
  assign w_region = w_addr & {{(ADDRBITS-LSBBITS){1'b1}}, {LSBBITS{1'b0}}};
  assign w_last   = r_idx == IW'(NUMLINES - 1);
  assign w_onehot = NUMLINES'(1) << r_idx;
  assign w_step   = ((r_state == FA_SCAN && !cache_line_dirty_vec[r_idx]) ||
                     (r_state == FA_WAIT_DONE && cache_line_ready_vec[r_idx])) && !w_last;

  // Strict less-than keeps the lowest index on ttl ties.
  always_comb begin
    w_vic = '0;
    w_min = cache_line_ttl_vec[TTLBITS-1:0];
    for (int i = 1; i < NUMLINES; i++)
      if (cache_line_ttl_vec[i*TTLBITS +: TTLBITS] < w_min) begin
        w_min = cache_line_ttl_vec[i*TTLBITS +: TTLBITS];
        w_vic = IW'(i);
      end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:         w_next = w_fa ? FA_SCAN : w_miss ? ISSUE : IDLE;
      ISSUE:        w_next = WAIT_BUSY;
      WAIT_BUSY:    w_next = cache_line_ready_vec[r_idx] ? WAIT_BUSY : WAIT_DONE;
      WAIT_DONE:    w_next = cache_line_ready_vec[r_idx] ? IDLE : WAIT_DONE;
      FA_SCAN:      w_next = cache_line_dirty_vec[r_idx] ? FA_ISSUE : w_last ? FA_DONE : FA_SCAN;
      FA_ISSUE:     w_next = FA_WAIT_BUSY;
      FA_WAIT_BUSY: w_next = cache_line_ready_vec[r_idx] ? FA_WAIT_BUSY : FA_WAIT_DONE;
      FA_WAIT_DONE: w_next = !cache_line_ready_vec[r_idx] ? FA_WAIT_DONE : w_last ? FA_DONE : FA_SCAN;
      default:      w_next = IDLE;
    endcase
  end

  // r_idx holds the victim on the fill path and the scan position during flush_all.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_region <= '0;
      r_vdirty <= 1'b0;
      r_stall  <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_stall <= w_next != IDLE;
      r_pend  <= r_state != IDLE && (r_pend | flush_all_req);
      if (r_state == IDLE) begin
        r_idx <= w_fa ? '0 : w_vic;
        if (!w_fa && w_miss) begin
          r_region <= w_region;
          r_vdirty <= cache_line_dirty_vec[w_vic];
        end
      end else if (w_step) r_idx <= r_idx + 1'b1;
    end

  assign cache_line_fill_vec  = r_state == ISSUE ? w_onehot : '0;
  assign cache_line_flush_vec = (r_state == FA_ISSUE || (r_state == ISSUE && r_vdirty)) ? w_onehot : '0;
  assign cache_new_region     = r_region;
  assign dcache_stall         = r_stall;
  assign icache_stall         = r_stall;
  assign flush_all_done       = r_state == FA_DONE;
endmodule

// File: tb/tb_cache_line_controller.sv
// tb_cache_line_controller: directed and randomized checks of cache_line_controller
// against a transaction-level model of the fill / flush_all protocol.
module tb_cache_line_controller;
  localparam int N = 4, A = 32, L = 7, T = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic [A-1:0] dcache_rdaddr, dcache_wraddr, icache_rdaddr;
  logic dcache_rdreq, dcache_wrreq, icache_rdreq, flush_all_req;
  logic [N-1:0] dvalid, wrhit, ivalid, ready, dirty;
  logic [N*T-1:0] ttl;
  logic [N-1:0] flush_vec, fill_vec;
  logic [A-1:0] region;
  logic dstall, istall, done;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cache_line_controller #(.NUMLINES(N), .ADDRBITS(A), .LSBBITS(L), .TTLBITS(T)) dut (
    .clk(clk), .reset(reset),
    .dcache_rdaddr(dcache_rdaddr), .dcache_rdreq(dcache_rdreq),
    .dcache_wraddr(dcache_wraddr), .dcache_wrreq(dcache_wrreq),
    .icache_rdaddr(icache_rdaddr), .icache_rdreq(icache_rdreq),
    .dcache_line_out_valid_vec(dvalid), .dcache_line_wrhit_vec(wrhit),
    .icache_line_out_valid_vec(ivalid), .cache_line_ready_vec(ready),
    .cache_line_dirty_vec(dirty), .cache_line_ttl_vec(ttl),
    .cache_line_flush_vec(flush_vec), .cache_line_fill_vec(fill_vec),
    .cache_new_region(region), .dcache_stall(dstall), .icache_stall(istall),
    .flush_all_req(flush_all_req), .flush_all_done(done)
  );

  // Model: expected outputs for the current cycle, updated at each clock edge.
  logic [N-1:0] e_flush, e_fill;
  logic [A-1:0] e_region;
  logic e_stall, e_done;
  bit ab, pend;

  task automatic tick();
    @(posedge clk or posedge reset);
    if (reset) ab = 1;
    else if (flush_all_req && e_stall) pend = 1;
  endtask

  task automatic await_ready(input int i, input logic lvl);
    do tick(); while (!ab && ready[i] != lvl);
  endtask

  function automatic int victim();
    int v = 0;
    for (int i = 1; i < N; i++) if (ttl[i*T +: T] < ttl[v*T +: T]) v = i;
    return v;
  endfunction

  task automatic do_fill(input int v, input logic [A-1:0] a);
    e_fill = N'(1) << v;
    e_flush = dirty[v] ? N'(1) << v : '0;
    e_region = {a[A-1:L], {L{1'b0}}};
    e_stall = 1;
    tick(); if (ab) return;
    e_fill = '0; e_flush = '0;
    await_ready(v, 1'b0); if (ab) return;
    await_ready(v, 1'b1); if (ab) return;
    e_stall = 0;
  endtask

  task automatic do_fa();
    e_stall = 1;
    for (int i = 0; i < N; i++) begin
      tick(); if (ab) return;
      if (dirty[i]) begin
        e_flush = N'(1) << i;
        tick(); if (ab) return;
        e_flush = '0;
        await_ready(i, 1'b0); if (ab) return;
        await_ready(i, 1'b1); if (ab) return;
      end
    end
    e_done = 1;
    tick(); if (ab) return;
    e_done = 0; e_stall = 0;
  endtask

  task automatic idle_step();
    tick(); if (ab) return;
    if (flush_all_req || pend) begin pend = 0; do_fa(); end
    else if (&ready) begin
      if (dcache_wrreq && !(|wrhit)) do_fill(victim(), dcache_wraddr);
      else if (dcache_rdreq && !(|dvalid)) do_fill(victim(), dcache_rdaddr);
      else if (icache_rdreq && !(|ivalid)) do_fill(victim(), icache_rdaddr);
    end
  endtask

  initial forever begin
    ab = 0; pend = 0; e_flush = '0; e_fill = '0; e_region = '0; e_stall = 0; e_done = 0;
    wait (!reset);
    while (!ab) idle_step();
  end

  // Cache-line array stand-in: a commanded line stays ready a few cycles, goes busy, then returns.
  bit auto = 1;
  int hold[N], busy[N];
  bit act[N], fl[N];

  task automatic emulate();
    for (int i = 0; i < N; i++)
      if (fill_vec[i] || flush_vec[i]) begin
        act[i] = 1; fl[i] = flush_vec[i];
        hold[i] = int'($urandom_range(0, 4)); busy[i] = int'($urandom_range(1, 6));
      end else if (act[i]) begin
        if (hold[i] > 0) hold[i]--;
        else if (ready[i]) ready[i] = 0;
        else if (busy[i] > 1) busy[i]--;
        else begin ready[i] = 1; act[i] = 0; if (fl[i]) dirty[i] = 0; end
      end
  endtask

  task automatic chk(input string n, input logic [A-1:0] got, input logic [A-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("flush_vec", A'(flush_vec), reset ? '0 : A'(e_flush));
    chk("fill_vec", A'(fill_vec), reset ? '0 : A'(e_fill));
    chk("new_region", region, reset ? '0 : e_region);
    chk("dcache_stall", A'(dstall), reset ? '0 : A'(e_stall));
    chk("icache_stall", A'(istall), reset ? '0 : A'(e_stall));
    chk("flush_all_done", A'(done), reset ? '0 : A'(e_done));
    if (auto && !reset) emulate();
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin cyc(); k++; end while ((dstall || e_stall) && k < 200);
    chk("idle_timeout", A'(dstall), '0);
  endtask

  int np, nf, nd;
  logic [N-1:0] q[$];

  initial begin
    dcache_rdaddr = '0; dcache_wraddr = '0; icache_rdaddr = '0;
    dcache_rdreq = 0; dcache_wrreq = 0; icache_rdreq = 0; flush_all_req = 0;
    dvalid = '0; wrhit = '0; ivalid = '0; ready = '1; dirty = '0;
    ttl = {8'd200, 8'd10, 8'd10, 8'd40};
    #1 reset = 1;
    repeat (2) cyc();
    reset = 0;
    cyc();
    chk("rst_region", region, '0);
    chk("rst_stall", A'(istall), '0);

    icache_rdaddr = 32'h0000_1234; icache_rdreq = 1;
    cyc();
    chk("t1_fill", A'(fill_vec), 32'b0010);
    chk("t1_flush", A'(flush_vec), '0);
    chk("t1_region", region, 32'h0000_1200);
    chk("t1_istall", A'(istall), 32'd1);
    chk("t1_model_fill", A'(e_fill), 32'b0010);
    icache_rdreq = 0;
    wait_idle();

    dirty = 4'b0010; dcache_wraddr = 32'h8000_0084; dcache_wrreq = 1;
    cyc();
    chk("t2_flush", A'(flush_vec), 32'b0010);
    chk("t2_fill", A'(fill_vec), 32'b0010);
    chk("t2_region", region, 32'h8000_0080);
    chk("t2_model_region", e_region, 32'h8000_0080);
    dcache_wrreq = 0;
    cyc();
    chk("t2_fill_once", A'(fill_vec), '0);
    chk("t2_flush_once", A'(flush_vec), '0);
    wait_idle();

    dcache_wraddr = 32'h100; dcache_rdaddr = 32'h200; icache_rdaddr = 32'h300;
    dcache_wrreq = 1; dcache_rdreq = 1; icache_rdreq = 1;
    cyc();
    chk("t3_first", region, 32'h100);
    wrhit = 4'b0001;
    wait_idle();
    cyc();
    chk("t3_second", region, 32'h200);
    dvalid = 4'b0001;
    wait_idle();
    cyc();
    chk("t3_third", region, 32'h300);
    dcache_wrreq = 0; dcache_rdreq = 0; icache_rdreq = 0;
    wrhit = '0; dvalid = '0;
    wait_idle();

    auto = 0;
    icache_rdaddr = 32'h4000; icache_rdreq = 1;
    cyc();
    chk("t4_fill", A'(fill_vec), 32'b0010);
    icache_rdreq = 0;
    np = 0;
    repeat (5) begin cyc(); np += int'(fill_vec != 0); end
    ready[1] = 0;
    repeat (34) begin cyc(); np += int'(fill_vec != 0); end
    chk("t4_stall_held", A'(istall), 32'd1);
    ready[1] = 1;
    cyc();
    chk("t4_dstall_drop", A'(dstall), '0);
    chk("t4_istall_drop", A'(istall), '0);
    chk("t4_no_repulse", A'(np), '0);
    auto = 1;

    dirty = 4'b1010; flush_all_req = 1;
    cyc();
    flush_all_req = 0;
    q.delete(); nf = 0; nd = 0;
    for (int k = 0; k < 200 && nd == 0; k++) begin
      cyc();
      if (flush_vec != 0) q.push_back(flush_vec);
      nf += int'(fill_vec != 0);
      nd += int'(done);
    end
    cyc();
    nd += int'(done);
    chk("t5_npulses", A'(q.size()), 32'd2);
    chk("t5_first", q.size() > 0 ? A'(q[0]) : '0, 32'b0010);
    chk("t5_second", q.size() > 1 ? A'(q[1]) : '0, 32'b1000);
    chk("t5_no_fill", A'(nf), '0);
    chk("t5_done_once", A'(nd), 32'd1);
    wait_idle();

    auto = 0;
    dcache_rdaddr = 32'h2000; dcache_rdreq = 1;
    cyc();
    chk("t6_fill", A'(fill_vec), 32'b0010);
    cyc();
    #2 reset = 1;
    #1;
    chk("t6_rst_dstall", A'(dstall), '0);
    chk("t6_rst_region", region, '0);
    chk("t6_rst_fill", A'(fill_vec), '0);
    repeat (2) cyc();
    reset = 0; auto = 1;
    cyc();
    chk("t6_refill", A'(fill_vec), 32'b0010);
    chk("t6_reregion", region, 32'h2000);
    dcache_rdreq = 0;
    wait_idle();

    for (int k = 0; k < 4000; k++) begin
      cyc();
      dcache_rdaddr = $urandom; dcache_wraddr = $urandom; icache_rdaddr = $urandom;
      dcache_rdreq = 1'($urandom_range(0, 1));
      dcache_wrreq = 1'($urandom_range(0, 1));
      icache_rdreq = 1'($urandom_range(0, 1));
      dvalid = $urandom_range(0, 1) ? N'(1) << $urandom_range(0, N - 1) : '0;
      wrhit  = $urandom_range(0, 1) ? N'(1) << $urandom_range(0, N - 1) : '0;
      ivalid = $urandom_range(0, 1) ? N'(1) << $urandom_range(0, N - 1) : '0;
      for (int i = 0; i < N; i++) ttl[i*T +: T] = T'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) dirty = N'($urandom);
      flush_all_req = $urandom_range(0, 49) == 0;
    end
    dcache_rdreq = 0; dcache_wrreq = 0; icache_rdreq = 0; flush_all_req = 0;
    wait_idle();
    repeat (2) wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
